// File: rtl/dom_present_inv_sbox.sv
// Two-share DOM-masked PRESENT inverse S-box: 3-stage pipe (4 with INV_SBOX_OUT_REFRESH_EN, which adds a
// share-refresh output stage on r_ref). en=0 freezes every register; one nibble per enabled cycle.
module dom_present_inv_sbox (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  input  logic [3:0] x_0,
  input  logic [3:0] x_1,
  input  logic [7:0] r,
`ifdef INV_SBOX_OUT_REFRESH_EN
  input  logic [3:0] r_ref,
`endif
  output logic       out_valid,
  output logic [3:0] y_0,
  output logic [3:0] y_1,
  output logic       busy
);

`ifdef INV_SBOX_OUT_REFRESH_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 3;
`endif

  // y = L(x, q, p) where q = layer-1 products and p = layer-2 products.
  function automatic logic [3:0] out_lin(input logic [3:0] x, input logic [3:0] q,
                                         input logic [3:0] p);
    logic [3:0] o;
    o[0] = x[0] ^ x[2] ^ q[1];
    o[1] = x[0] ^ x[1] ^ x[3] ^ p[0] ^ p[1] ^ p[3] ^ q[1] ^ q[2] ^ q[3];
    o[2] = x[3] ^ p[0] ^ p[1] ^ p[2] ^ q[0] ^ q[1] ^ q[3];
    o[3] = x[0] ^ x[1] ^ x[2] ^ x[3] ^ p[0];
    return o;
  endfunction

  logic [DEPTH-1:0] vld;

  // Layer 1 gadgets, bit order {x0&x2, x2&x3, x1&x3, x1&x2}
  logic [3:0] l1a_0, l1b_0, l1a_1, l1b_1;
  assign l1a_0 = {x_0[0], x_0[2], x_0[1], x_0[1]};
  assign l1b_0 = {x_0[2], x_0[3], x_0[3], x_0[2]};
  assign l1a_1 = {x_1[0], x_1[2], x_1[1], x_1[1]};
  assign l1b_1 = {x_1[2], x_1[3], x_1[3], x_1[2]};

  logic [3:0] s1_x0, s1_x1, s1_c0, s1_c1, s1_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_x0 <= '0;
      s1_x1 <= '0;
      s1_c0 <= '0;
      s1_c1 <= '0;
      s1_r  <= '0;
    end else if (en) begin
      s1_x0 <= x_0;
      s1_x1 <= x_1;
      s1_c0 <= (l1a_0 & l1b_1) ^ r[3:0];
      s1_c1 <= (l1a_1 & l1b_0) ^ r[3:0];
      s1_r  <= r[7:4];
    end
  end

  // Inner-domain terms are recomputed from the registered shares of their own domain only.
  logic [3:0] s1a_0, s1b_0, s1a_1, s1b_1, q_0, q_1, l2b_0, l2b_1;
  assign s1a_0 = {s1_x0[0], s1_x0[2], s1_x0[1], s1_x0[1]};
  assign s1b_0 = {s1_x0[2], s1_x0[3], s1_x0[3], s1_x0[2]};
  assign s1a_1 = {s1_x1[0], s1_x1[2], s1_x1[1], s1_x1[1]};
  assign s1b_1 = {s1_x1[2], s1_x1[3], s1_x1[3], s1_x1[2]};
  assign q_0   = (s1a_0 & s1b_0) ^ s1_c0;
  assign q_1   = (s1a_1 & s1b_1) ^ s1_c1;

  // Layer 2: every gadget has a = x0; b = {x1, x3, q1, q0^q2^x1}
  assign l2b_0 = {s1_x0[1], s1_x0[3], q_0[1], q_0[0] ^ q_0[2] ^ s1_x0[1]};
  assign l2b_1 = {s1_x1[1], s1_x1[3], q_1[1], q_1[0] ^ q_1[2] ^ s1_x1[1]};

  logic [3:0] s2_x0, s2_x1, s2_q0, s2_q1, s2_c0, s2_c1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_x0 <= '0;
      s2_x1 <= '0;
      s2_q0 <= '0;
      s2_q1 <= '0;
      s2_c0 <= '0;
      s2_c1 <= '0;
    end else if (en) begin
      s2_x0 <= s1_x0;
      s2_x1 <= s1_x1;
      s2_q0 <= q_0;
      s2_q1 <= q_1;
      s2_c0 <= ({4{s1_x0[0]}} & l2b_1) ^ s1_r;
      s2_c1 <= ({4{s1_x1[0]}} & l2b_0) ^ s1_r;
    end
  end

  logic [3:0] s2b_0, s2b_1, p_0, p_1, f_0, f_1;
  assign s2b_0 = {s2_x0[1], s2_x0[3], s2_q0[1], s2_q0[0] ^ s2_q0[2] ^ s2_x0[1]};
  assign s2b_1 = {s2_x1[1], s2_x1[3], s2_q1[1], s2_q1[0] ^ s2_q1[2] ^ s2_x1[1]};
  assign p_0   = ({4{s2_x0[0]}} & s2b_0) ^ s2_c0;
  assign p_1   = ({4{s2_x1[0]}} & s2b_1) ^ s2_c1;
  // Affine constant lands on share 0 only.
  assign f_0   = out_lin(s2_x0, s2_q0, p_0) ^ 4'h5;
  assign f_1   = out_lin(s2_x1, s2_q1, p_1);

  logic [3:0] s3_0, s3_1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_0 <= '0;
      s3_1 <= '0;
    end else if (en) begin
      s3_0 <= f_0;
      s3_1 <= f_1;
    end
  end

`ifdef INV_SBOX_OUT_REFRESH_EN
  logic [3:0] s4_0, s4_1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s4_0 <= '0;
      s4_1 <= '0;
    end else if (en) begin
      s4_0 <= s3_0 ^ r_ref;
      s4_1 <= s3_1 ^ r_ref;
    end
  end

  assign y_0 = s4_0;
  assign y_1 = s4_1;
`else
  assign y_0 = s3_0;
  assign y_1 = s3_1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[DEPTH-2:0], in_valid};
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign busy      = |vld;

endmodule

// File: tb/tb_dom_present_inv_sbox.sv
// Bench for dom_present_inv_sbox: vector table plus stall, bubble, reset and refresh sequences,
// with results matched through an in-order scoreboard that also checks enabled-cycle latency.
module tb_dom_present_inv_sbox;
  logic       clk = 1'b0;
  logic       rst, en, in_valid;
  logic [3:0] x_0, x_1;
  logic [7:0] r;
  logic       out_valid, busy;
  logic [3:0] y_0, y_1;
`ifdef INV_SBOX_OUT_REFRESH_EN
  logic [3:0] r_ref;
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  dom_present_inv_sbox dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .x_0(x_0), .x_1(x_1), .r(r),
`ifdef INV_SBOX_OUT_REFRESH_EN
    .r_ref(r_ref),
`endif
    .out_valid(out_valid), .y_0(y_0), .y_1(y_1), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] res; int due; int tag; } sb_t;
  typedef struct { logic [3:0] x0; logic [3:0] x1; logic [7:0] r; logic [3:0] res; } vec_t;

  sb_t        sb[$];
  vec_t       vt [17];
  logic [3:0] inv_tab [16];
  logic [3:0] cap_y0 [8];
  logic [63:0] inv_packed;
  int   n_vec = 0;
  int   n_bad = 0;
  int   en_edges = 0;
  logic adv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  always @(posedge clk) begin
    adv <= en && !rst;
    if (en && !rst) en_edges <= en_edges + 1;
  end

  // Scoreboard: one compare per freshly produced output
  always @(negedge clk) begin
    sb_t e;
    if (adv && out_valid) begin
      if (sb.size() == 0) begin
        check("stray_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", {28'b0, y_0 ^ y_1}, {28'b0, e.res});
        check("latency", en_edges, e.due);
        if (e.tag >= 0) cap_y0[e.tag] <= y_0;
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [7:0] rr, input logic [3:0] res, input logic push,
                       input int tag);
    rst = 1'b0; en = 1'b1; in_valid = v; x_0 = s0; x_1 = s1; r = rr;
    if (v && push) sb.push_back('{res: res, due: en_edges + LAT, tag: tag});
  endtask

  task automatic send(input logic [3:0] s0, input logic [3:0] s1, input logic [7:0] rr,
                      input logic [3:0] res, input logic push, input int tag);
    @(negedge clk);
    drive(1'b1, s0, s1, rr, res, push, tag);
  endtask

  task automatic idle();
    @(negedge clk);
    drive(1'b0, 4'($urandom), 4'($urandom), 8'($urandom), 4'h0, 1'b0, -1);
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 40) begin
      idle();
      k++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  initial begin
    logic       so_v;
    logic [3:0] so_y0, so_y1;

    inv_packed = 64'hA970_364B_D21C_8FE5;
    for (int i = 0; i < 16; i++) inv_tab[i] = inv_packed[i*4 +: 4];

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; x_0 = '0; x_1 = '0; r = '0;
`ifdef INV_SBOX_OUT_REFRESH_EN
    r_ref = 4'h0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_y_0", {28'b0, y_0}, 32'd0);
    check("rst_y_1", {28'b0, y_1}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;

    // Exhaustive table, back to back
    for (int i = 0; i < 16; i++) begin
      vt[i].x0  = 4'($urandom);
      vt[i].x1  = 4'(i) ^ vt[i].x0;
      vt[i].r   = 8'($urandom);
      vt[i].res = inv_tab[i];
    end
    vt[16] = '{x0: 4'h3, x1: 4'h3, r: 8'($urandom), res: 4'h5};
    for (int i = 0; i < 17; i++) send(vt[i].x0, vt[i].x1, vt[i].r, vt[i].res, 1'b1, -1);
    drain();

    // Mask independence for x = 0xA
    send(4'h0, 4'hA, 8'h00, 4'h6, 1'b1, 0);
    send(4'h0, 4'hA, 8'hFF, 4'h6, 1'b1, 1);
    send(4'hF, 4'h5, 8'h00, 4'h6, 1'b1, 2);
    send(4'hF, 4'h5, 8'hFF, 4'h6, 1'b1, 3);
    drain();
    check("mask_y0_varies", {31'b0, (cap_y0[0] != cap_y0[1]) || (cap_y0[2] != cap_y0[3])}, 32'd1);

    // Stall: x=7 sampled, one more enabled cycle, then en low for 5 cycles
    send(4'h2, 4'h5, 8'($urandom), 4'hD, 1'b1, -1);
    send(4'h9, 4'hB, 8'($urandom), 4'hF, 1'b1, -1);
    @(negedge clk);
    en = 1'b0; in_valid = 1'b1; x_0 = 4'($urandom); x_1 = 4'($urandom); r = 8'($urandom);
    so_v = out_valid; so_y0 = y_0; so_y1 = y_1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'b0, out_valid}, {31'b0, so_v});
      check("stall_y_0", {28'b0, y_0}, {28'b0, so_y0});
      check("stall_y_1", {28'b0, y_1}, {28'b0, so_y1});
      check("stall_busy", {31'b0, busy}, 32'd1);
      x_0 = 4'($urandom); x_1 = 4'($urandom); r = 8'($urandom);
      if (i == 4) begin en = 1'b1; in_valid = 1'b0; end
    end
    for (int k = 0; k <= LAT - 3; k++) begin
      @(negedge clk);
      check("stall_release_valid", {31'b0, out_valid}, {31'b0, k == LAT - 3});
    end
    drain();

    // Bubbles: in_valid 1,0,1
    for (int k = 0; k <= LAT + 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("bubble_out_valid", {31'b0, out_valid}, {31'b0, (k == LAT) || (k == LAT + 2)});
        check("bubble_busy", {31'b0, busy}, {31'b0, k < LAT + 3});
      end
      if (k == 0)      drive(1'b1, 4'h4, 4'h5, 8'($urandom), 4'hE, 1'b1, -1);
      else if (k == 2) drive(1'b1, 4'h7, 4'h5, 8'($urandom), 4'hF, 1'b1, -1);
      else             drive(1'b0, 4'($urandom), 4'($urandom), 8'($urandom), 4'h0, 1'b0, -1);
    end
    drain();

    // Reset with two nibbles in flight
    send(4'($urandom), 4'($urandom), 8'($urandom), 4'h0, 1'b0, -1);
    send(4'($urandom), 4'($urandom), 8'($urandom), 4'h0, 1'b0, -1);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_y_0", {28'b0, y_0}, 32'd0);
    check("midrst_y_1", {28'b0, y_1}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    drive(1'b0, 4'($urandom), 4'($urandom), 8'($urandom), 4'h0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("postrst_busy", {31'b0, busy}, 32'd0);
      drive(1'b0, 4'($urandom), 4'($urandom), 8'($urandom), 4'h0, 1'b0, -1);
    end

`ifdef INV_SBOX_OUT_REFRESH_EN
    // Output refresh: same shares and randomness, r_ref 0 then 9
    r_ref = 4'h0;
    send(4'h3, 4'hF, 8'h5A, 4'h0, 1'b1, 4);
    drain();
    r_ref = 4'h9;
    send(4'h3, 4'hF, 8'h5A, 4'h0, 1'b1, 5);
    drain();
    check("refresh_y0_delta", {28'b0, cap_y0[4] ^ cap_y0[5]}, 32'h9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d vectors applied, %0d miscompares", n_vec, n_bad);
    $fatal(1);
  end
endmodule
